// File: rtl/matrix_key_scanner.sv
// Row-scanning keypad front end: drives one row low at a time, debounces each key
// independently and queues press/release events in a small FIFO.
module matrix_key_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 5,
  parameter int DWELL      = 1024,
  parameter int DEB_SCANS  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [ROWS-1:0]      row_out,
  input  logic [COLS-1:0]      col_in,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [7:0]           evt_code,
  output logic                 evt_press,
  output logic                 overflow
);

  localparam int unsigned KEYS = ROWS * COLS;
  localparam int KW = (KEYS > 1) ? $clog2(KEYS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW = $clog2(DWELL);
  localparam int NW = (DEB_SCANS > 1) ? $clog2(DEB_SCANS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [COLS-1:0] col_meta, col_sync;
  logic            running;
  logic [RW-1:0]   row_idx;
  logic [DW-1:0]   dwell;
  logic [COLS-1:0] raw;
  logic [RW-1:0]   raw_row;
  logic            raw_valid;
  logic [NW-1:0]   cnt [KEYS];

  logic          eval_en, agree, flip, sample;
  logic [KW-1:0] key;
  logic [CW-1:0] col;

  logic [7:0]    mem_code  [FIFO_DEPTH];
  logic          mem_press [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic          full, pop, push_ok;

  // running stays low for the reset cycle so rows are only driven once scanning starts
  always_comb begin
    row_out = '1;
    if (running) row_out[row_idx] = 1'b0;
  end

  // The sample latched at the end of a row is evaluated one column per cycle
  // during the first COLS cycles of the following row.
  always_comb begin
    eval_en = running && raw_valid && (dwell < DW'(COLS));
    col     = CW'(dwell);
    key     = KW'(raw_row) * KW'(COLS) + KW'(dwell);
    sample  = raw[col];
    agree   = (sample == key_state[key]);
    flip    = eval_en && !agree && (cnt[key] == NW'(DEB_SCANS - 1));
  end

  always_comb begin
    evt_valid = (count != '0);
    full      = (count == (AW+1)'(FIFO_DEPTH));
    pop       = evt_valid && evt_ready;
    push_ok   = flip && (!full || pop);
    evt_code  = evt_valid ? mem_code[rp] : '0;
    evt_press = evt_valid && mem_press[rp];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta  <= '1;
      col_sync  <= '1;
      running   <= 1'b0;
      row_idx   <= '0;
      dwell     <= '0;
      raw       <= '0;
      raw_row   <= '0;
      raw_valid <= 1'b0;
      key_state <= '0;
      for (int unsigned i = 0; i < KEYS; i++) cnt[i] <= '0;
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
      running  <= 1'b1;

      if (running) begin
        if (dwell == DW'(DWELL - 1)) begin
          dwell     <= '0;
          row_idx   <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
          raw       <= ~col_sync;
          raw_row   <= row_idx;
          raw_valid <= 1'b1;
        end else begin
          dwell <= dwell + 1'b1;
        end
      end

      if (eval_en) begin
        if (agree) begin
          cnt[key] <= '0;
        end else if (flip) begin
          key_state[key] <= ~key_state[key];
          cnt[key]       <= '0;
        end else begin
          cnt[key] <= cnt[key] + 1'b1;
        end
      end

      if (push_ok) wp <= wp + 1'b1;
      if (pop)     rp <= rp + 1'b1;
      if (flip && full && !pop) overflow <= 1'b1;

      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_code[wp]  <= 8'(key);
      mem_press[wp] <= ~key_state[key];
    end
  end

endmodule

// File: tb/tb_matrix_key_scanner.sv
// Directed bench for matrix_key_scanner: a modelled key matrix feeds col_in from row_out,
// and each scenario checks scan timing, debounce, event FIFO and reset behaviour.
module tb_matrix_key_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_out;
  logic [4:0]  col_in;
  logic [19:0] key_state;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [7:0]  evt_code;
  logic        evt_press;
  logic        overflow;

  logic [19:0] pressed = '0;
  int          cyc = -1;
  int          checks = 0;
  int          errors = 0;
  logic [8:0]  ev_q [$];

  matrix_key_scanner #(
    .ROWS(4), .COLS(5), .DWELL(8), .DEB_SCANS(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .row_out(row_out), .col_in(col_in),
    .key_state(key_state), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_press(evt_press), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_in = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        if (!row_out[r] && pressed[r*5+c]) col_in[c] = 1'b0;
  end

  // cyc = 0 in the first cycle after the edge that samples rst low
  always @(posedge clk) begin
    if (rst) cyc <= -1;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) ev_q.push_back({evt_press, evt_code});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, cyc=%0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    ev_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (row_out !== 4'b1111) begin errors++; $display("FAIL reset_row_out: got %b expected 1111", row_out); end
    checks++;
    if ({key_state, evt_valid, evt_code, evt_press, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: key_state=%h valid=%b code=%h press=%b ovf=%b expected all 0",
               key_state, evt_valid, evt_code, evt_press, overflow);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (row_out !== 4'b1110) begin errors++; $display("FAIL scan_c0: got %b expected 1110", row_out); end
    goto(7);
    checks++;
    if (row_out !== 4'b1110) begin errors++; $display("FAIL scan_c7: got %b expected 1110", row_out); end
    goto(8);
    checks++;
    if (row_out !== 4'b1101) begin errors++; $display("FAIL scan_c8: got %b expected 1101", row_out); end
    goto(16);
    checks++;
    if (row_out !== 4'b1011) begin errors++; $display("FAIL scan_c16: got %b expected 1011", row_out); end
    goto(24);
    checks++;
    if (row_out !== 4'b0111) begin errors++; $display("FAIL scan_c24: got %b expected 0111", row_out); end
    goto(31);
    checks++;
    if (row_out !== 4'b0111) begin errors++; $display("FAIL scan_c31: got %b expected 0111", row_out); end
    goto(32);
    checks++;
    if (row_out !== 4'b1110) begin errors++; $display("FAIL scan_wrap_c32: got %b expected 1110", row_out); end
  endtask

  // Key 13 pressed in scan 0, released in scan 1, pressed again from scan 2:
  // the interruption clears progress so the flip lands on scan 4.
  task automatic test_press();
    pressed   = 20'h0;
    pressed[13] = 1'b1;
    evt_ready = 1'b1;
    do_reset();
    goto(32);  pressed[13] = 1'b0;
    goto(64);  pressed[13] = 1'b1;
    goto(124);
    checks++;
    if (key_state !== 20'h0) begin errors++; $display("FAIL press_cleared_state: got %h expected 00000", key_state); end
    checks++;
    if (ev_q.size() != 0) begin errors++; $display("FAIL press_cleared_events: got %0d expected 0", ev_q.size()); end
    goto(156);
    checks++;
    if (key_state !== 20'h02000) begin errors++; $display("FAIL press_state: got %h expected 02000", key_state); end
    checks++;
    if ({evt_valid, evt_press, evt_code} !== {1'b1, 1'b1, 8'd13}) begin
      errors++;
      $display("FAIL press_event: valid=%b press=%b code=%0d expected 1 1 13", evt_valid, evt_press, evt_code);
    end
    goto(157);
    checks++;
    if (ev_q.size() != 1 || ev_q[0] !== {1'b1, 8'd13}) begin
      errors++;
      $display("FAIL press_popped: size=%0d head=%h expected 1 entry 10d", ev_q.size(), (ev_q.size() > 0) ? ev_q[0] : 9'h0);
    end
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL press_drained: got %b expected 0", evt_valid); end
  endtask

  // A 2-scan release glitch is ignored; a 3-scan release produces one release event.
  task automatic test_release();
    goto(160); pressed[13] = 1'b0;
    goto(224); pressed[13] = 1'b1;
    goto(256); pressed[13] = 1'b0;
    goto(340);
    checks++;
    if (key_state !== 20'h02000 || ev_q.size() != 1) begin
      errors++;
      $display("FAIL release_glitch: state=%h events=%0d expected 02000 1", key_state, ev_q.size());
    end
    goto(348);
    checks++;
    if (key_state !== 20'h0) begin errors++; $display("FAIL release_state: got %h expected 00000", key_state); end
    checks++;
    if ({evt_valid, evt_press, evt_code} !== {1'b1, 1'b0, 8'd13}) begin
      errors++;
      $display("FAIL release_event: valid=%b press=%b code=%0d expected 1 0 13", evt_valid, evt_press, evt_code);
    end
    goto(349);
    checks++;
    if (ev_q.size() != 2 || ev_q[1] !== {1'b0, 8'd13}) begin
      errors++;
      $display("FAIL release_popped: size=%0d expected 2 with last 00d", ev_q.size());
    end
  endtask

  task automatic test_overflow();
    pressed   = 20'h003E0;
    evt_ready = 1'b0;
    do_reset();
    goto(81);
    checks++;
    if ({evt_valid, evt_press, evt_code} !== {1'b1, 1'b1, 8'd5}) begin
      errors++;
      $display("FAIL ovf_first_event: valid=%b press=%b code=%0d expected 1 1 5", evt_valid, evt_press, evt_code);
    end
    goto(84);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before_drop: got %b expected 0", overflow); end
    goto(85);
    checks++;
    if (key_state !== 20'h003E0) begin errors++; $display("FAIL ovf_state: got %h expected 003e0", key_state); end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    goto(100);
    checks++;
    if ({evt_valid, evt_code, overflow} !== {1'b1, 8'd5, 1'b1}) begin
      errors++;
      $display("FAIL ovf_head_stable: valid=%b code=%0d ovf=%b expected 1 5 1", evt_valid, evt_code, overflow);
    end
  endtask

  // Pop coinciding with a push into a full buffer: both accepted.
  task automatic test_back_to_back();
    goto(101);
    pressed[5] = 1'b0;
    ev_q.delete();
    goto(176);
    evt_ready = 1'b1;
    goto(177);
    evt_ready = 1'b0;
    checks++;
    if ({evt_valid, evt_press, evt_code} !== {1'b1, 1'b1, 8'd6}) begin
      errors++;
      $display("FAIL b2b_head: valid=%b press=%b code=%0d expected 1 1 6", evt_valid, evt_press, evt_code);
    end
    checks++;
    if (key_state !== 20'h003C0) begin errors++; $display("FAIL b2b_state: got %h expected 003c0", key_state); end
    goto(180);
    evt_ready = 1'b1;
    goto(190);
    checks++;
    if (ev_q.size() != 5) begin
      errors++;
      $display("FAIL b2b_count: got %0d pops expected 5", ev_q.size());
    end else begin
      checks++;
      if (ev_q[0] !== 9'h105 || ev_q[1] !== 9'h106 || ev_q[2] !== 9'h107 || ev_q[3] !== 9'h108 || ev_q[4] !== 9'h005) begin
        errors++;
        $display("FAIL b2b_order: got %h %h %h %h %h expected 105 106 107 108 005",
                 ev_q[0], ev_q[1], ev_q[2], ev_q[3], ev_q[4]);
      end
    end
    checks++;
    if (evt_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drained: valid=%b ovf=%b expected 0 1", evt_valid, overflow);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    pressed   = 20'h00060;
    evt_ready = 1'b0;
    do_reset();
    goto(82);
    checks++;
    if ({evt_valid, evt_code} !== {1'b1, 8'd5}) begin
      errors++;
      $display("FAIL midrst_pre: valid=%b code=%0d expected 1 5", evt_valid, evt_code);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({evt_valid, overflow, key_state, row_out, evt_code} !== {1'b0, 1'b0, 20'h0, 4'b1111, 8'd0}) begin
      errors++;
      $display("FAIL midrst_cleared: valid=%b ovf=%b state=%h row=%b code=%0d expected 0 0 00000 1111 0",
               evt_valid, overflow, key_state, row_out, evt_code);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (row_out !== 4'b1110) begin errors++; $display("FAIL midrst_restart: got %b expected 1110", row_out); end
    goto(8);
    checks++;
    if (row_out !== 4'b1101) begin errors++; $display("FAIL midrst_row1: got %b expected 1101", row_out); end
    goto(20);
    checks++;
    if (key_state !== 20'h0 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_stale: state=%h valid=%b expected 00000 0", key_state, evt_valid);
    end
    goto(81);
    checks++;
    if ({key_state, evt_valid, evt_press, evt_code} !== {20'h00020, 1'b1, 1'b1, 8'd5}) begin
      errors++;
      $display("FAIL midrst_rescan: state=%h valid=%b press=%b code=%0d expected 00020 1 1 5",
               key_state, evt_valid, evt_press, evt_code);
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
